// File: rtl/arbiter.sv
// Round-robin arbiter for 16 channel FIFOs; frames each grant onto a gapless
// 16-bit link word stream with 8b/10b K-character flags and deferred triggers.
//
// state   | meaning
// ST_IDLE | between frames: emit TRIG if pending, else grant a channel (SOF), else IDLE word
// ST_DATA | strobing the granted channel until it empties or 256 words are read
// ST_EOF  | emit EOF word, return to ST_IDLE
module arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] data,
  input  logic [15:0]  req,
  output logic [15:0]  ack,
  input  logic         trigger,
  output logic [15:0]  dout,
  output logic         kchar
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_EOF  = 2'd2;

  localparam logic [15:0] W_IDLE = 16'h50BC;
  localparam logic [15:0] W_EOF  = 16'h00FD;
  localparam logic [15:0] W_TRIG = 16'h00F7;
  localparam logic [8:0]  MAX_WORDS = 9'd256;

  logic [1:0]  state_q, state_d;
  logic [3:0]  ch_q, ch_d;
  logic [8:0]  count_q, count_d;
  logic [3:0]  rr_q, rr_d;
  logic        pend_q, pend_d;
  logic        acked_q, acked_d;
  logic [15:0] dout_q, dout_d;
  logic        kchar_q, kchar_d;

  logic [15:0] ack_c;
  logic        sel_found;
  logic [3:0]  sel_ch;
  logic [3:0]  rr_idx;

  // First requesting channel at or after the round-robin pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = rr_q;
    rr_idx    = rr_q;
    for (int i = 0; i < 16; i++) begin
      rr_idx = rr_q + 4'(i);
      if (!sel_found && req[rr_idx]) begin
        sel_found = 1'b1;
        sel_ch    = rr_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    count_d = count_q;
    rr_d    = rr_q;
    pend_d  = pend_q | trigger;
    ack_c   = '0;
    dout_d  = W_IDLE;
    kchar_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          dout_d = W_TRIG;
          pend_d = trigger;
        end else if (sel_found) begin
          ack_c[sel_ch] = 1'b1;
          dout_d  = {4'h0, sel_ch, 8'h1C};
          count_d = 9'd1;
          rr_d    = sel_ch + 4'd1;
          ch_d    = sel_ch;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (req[ch_q] && (count_q < MAX_WORDS)) begin
          ack_c[ch_q] = 1'b1;
          count_d     = count_q + 9'd1;
        end else begin
          state_d = ST_EOF;
        end
      end
      ST_EOF: begin
        dout_d  = W_EOF;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The word strobed last cycle is on its lane now and always goes out next.
    if (acked_q) begin
      dout_d  = data[{ch_q, 4'b0000} +: 16];
      kchar_d = 1'b0;
    end

    if (reset) begin
      ack_c = '0;
    end
    acked_d = |ack_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= 4'd0;
      count_q <= 9'd0;
      rr_q    <= 4'd0;
      pend_q  <= 1'b0;
      acked_q <= 1'b0;
      dout_q  <= W_IDLE;
      kchar_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      acked_q <= acked_d;
      dout_q  <= dout_d;
      kchar_q <= kchar_d;
    end
  end

  assign ack   = ack_c;
  assign dout  = dout_q;
  assign kchar = kchar_q;

endmodule

// File: tb/tb_arbiter.sv
// Bench for arbiter: 16 modelled FIFOs, a stream parser that rebuilds expected
// frames from loaded data and round-robin order, plus directed scenarios.
module tb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] data = '0;
  logic [15:0]  req = '0;
  logic [15:0]  ack;
  logic         trigger;
  logic [15:0]  dout;
  logic         kchar;

  always #5 clk = ~clk;

  arbiter dut (
    .clk(clk), .reset(reset), .data(data), .req(req), .ack(ack),
    .trigger(trigger), .dout(dout), .kchar(kchar)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // FIFO storage: loaded words are kept; f_rd is the FIFO read side, m_rd the model's.
  logic [15:0] fmem [16][2048];
  int f_wr [16] = '{default: 0};
  int f_rd [16] = '{default: 0};
  int ack_cnt [16] = '{default: 0};
  logic [15:0] ack_s = '0;
  logic [15:0] req_nxt;

  always @(negedge clk) begin
    #4;
    ack_s = ack;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (ack_s[i]) ack_cnt[i] = ack_cnt[i] + 1;
      if (ack_s[i] && f_rd[i] < f_wr[i]) begin
        data[16*i +: 16] <= fmem[i][f_rd[i]];
        f_rd[i] = f_rd[i] + 1;
      end
      req_nxt[i] = (f_rd[i] < f_wr[i]);
    end
    req <= req_nxt;
  end

  // Stream model state
  bit          mon_en = 1'b0;
  bit          m_in_frame = 1'b0;
  logic [3:0]  m_ch = 4'd0;
  int          m_len = 0;
  int          m_cnt = 0;
  logic [3:0]  m_rr = 4'd0;
  int          m_rd [16] = '{default: 0};
  int          trig_edges [$];
  logic [15:0] req_prev = '0;
  logic [16:0] log_w [$];
  int          log_c [$];

  task automatic mon_init();
    m_in_frame = 1'b0;
    m_rr = 4'd0;
    for (int i = 0; i < 16; i++) m_rd[i] = f_rd[i];
    trig_edges.delete();
    req_prev = req;
  endtask

  task automatic log_clear();
    log_w.delete();
    log_c.delete();
  endtask

  // Word seen now was produced in the previous cycle, from triggers sampled
  // two edges back and from the requests that were visible then.
  task automatic mon_step();
    bit pend_old;
    bit found;
    logic [3:0] exp_ch;
    logic [3:0] idx;
    logic [15:0] exp_w;
    pend_old = (trig_edges.size() > 0) && (trig_edges[0] <= cyc - 2);

    n_vec++;
    if (((ack & ~req) != 16'h0) || !$onehot0(ack)) begin
      n_err++;
      $display("FAIL ack_legal: ack=%h req=%h cyc=%0d", ack, req, cyc);
    end

    n_vec++;
    if (!(kchar === 1'b1 && dout === 16'h50BC)) begin
      log_w.push_back({kchar, dout});
      log_c.push_back(cyc);
    end
    if (m_in_frame) begin
      if (m_cnt < m_len) begin
        exp_w = fmem[m_ch][m_rd[m_ch]];
        if (dout !== exp_w || kchar !== 1'b0) begin
          n_err++;
          $display("FAIL data_word: got %h k=%b want %h k=0 cyc=%0d", dout, kchar, exp_w, cyc);
        end
        m_rd[m_ch] = m_rd[m_ch] + 1;
        m_cnt++;
      end else begin
        if (dout !== 16'h00FD || kchar !== 1'b1) begin
          n_err++;
          $display("FAIL eof_word: got %h k=%b want 00fd k=1 cyc=%0d", dout, kchar, cyc);
        end
        m_in_frame = 1'b0;
      end
    end else if (kchar === 1'b1 && dout === 16'h00F7) begin
      if (!pend_old) begin
        n_err++;
        $display("FAIL trig_word: got unrequested 00f7 want none cyc=%0d", cyc);
      end
      while (trig_edges.size() > 0 && trig_edges[0] <= cyc - 2) void'(trig_edges.pop_front());
    end else if (kchar === 1'b1 && dout[7:0] === 8'h1C && dout[15:12] === 4'h0) begin
      found = 1'b0;
      exp_ch = 4'd0;
      for (int j = 0; j < 16; j++) begin
        idx = m_rr + 4'(j);
        if (!found && req_prev[idx]) begin
          found = 1'b1;
          exp_ch = idx;
        end
      end
      if (pend_old || !found || dout[11:8] !== exp_ch) begin
        n_err++;
        $display("FAIL sof_word: got %h want %h (found=%0d pend=%0d) cyc=%0d",
                 dout, {4'h0, exp_ch, 8'h1C}, found, pend_old, cyc);
      end
      m_ch = dout[11:8];
      m_len = f_wr[m_ch] - m_rd[m_ch];
      if (m_len > 256) m_len = 256;
      m_cnt = 0;
      m_in_frame = 1'b1;
      m_rr = m_ch + 4'd1;
    end else if (kchar === 1'b1 && dout === 16'h50BC) begin
      if (pend_old || req_prev != 16'h0) begin
        n_err++;
        $display("FAIL idle_word: got 50bc want work (req=%h pend=%0d) cyc=%0d", req_prev, pend_old, cyc);
      end
    end else begin
      n_err++;
      $display("FAIL link_word: got %h k=%b want a legal word cyc=%0d", dout, kchar, cyc);
    end
    req_prev = req;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mon_en) mon_step();
  endtask

  task automatic load(input int ch, input int n, input logic [15:0] base, input bit rnd);
    for (int j = 0; j < n; j++) begin
      fmem[ch][f_wr[ch]] = rnd ? 16'($urandom) : base + 16'(j);
      f_wr[ch] = f_wr[ch] + 1;
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    trigger = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mon_init();
    mon_en = 1'b1;
  endtask

  task automatic run_drain(input int budget, input bit rnd_trig);
    int k;
    int streak;
    bit done;
    k = 0;
    streak = 0;
    while (streak < 4 && k < budget) begin
      tick();
      k++;
      if (rnd_trig && k < budget / 2 && $urandom_range(0, 24) == 0) begin
        trigger = 1'b1;
        trig_edges.push_back(cyc);
      end else begin
        trigger = 1'b0;
      end
      done = !m_in_frame && (trig_edges.size() == 0) && (trigger == 1'b0);
      for (int i = 0; i < 16; i++) if (m_rd[i] != f_wr[i]) done = 1'b0;
      streak = done ? streak + 1 : 0;
    end
    trigger = 1'b0;
    n_vec++;
    if (streak < 4) begin
      n_err++;
      $display("FAIL drain_timeout: got not drained after %0d cycles want drained", budget);
    end
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    trigger = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (dout !== 16'h50BC || kchar !== 1'b1 || ack !== 16'h0) begin
        n_err++;
        $display("FAIL reset_held: got %h k=%b ack=%h want 50bc k=1 ack=0", dout, kchar, ack);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (dout !== 16'h50BC || kchar !== 1'b1 || ack !== 16'h0) begin
        n_err++;
        $display("FAIL reset_idle: got %h k=%b ack=%h want 50bc k=1 ack=0", dout, kchar, ack);
      end
    end
    mon_init();
    mon_en = 1'b1;
  endtask

  task automatic test_single_frame();
    int a0;
    log_clear();
    a0 = ack_cnt[2];
    load(2, 10, 16'h0000, 1'b0);
    run_drain(200, 1'b0);
    n_vec++;
    if (log_w.size() != 12) begin
      n_err++;
      $display("FAIL ch2_len: got %0d words want 12", log_w.size());
    end else begin
      if (log_w[0] !== 17'h1021C) begin
        n_err++;
        $display("FAIL ch2_sof: got %h want 1021c", log_w[0]);
      end
      for (int i = 0; i < 10; i++) begin
        n_vec++;
        if (log_w[1+i] !== 17'(i) || log_c[1+i] != log_c[0] + 1 + i) begin
          n_err++;
          $display("FAIL ch2_data%0d: got %h at %0d want %h at %0d", i, log_w[1+i], log_c[1+i], i, log_c[0]+1+i);
        end
      end
      n_vec++;
      if (log_w[11] !== 17'h100FD) begin
        n_err++;
        $display("FAIL ch2_eof: got %h want 100fd", log_w[11]);
      end
    end
    n_vec++;
    if (ack_cnt[2] - a0 != 10) begin
      n_err++;
      $display("FAIL ch2_acks: got %0d want 10", ack_cnt[2] - a0);
    end
  endtask

  task automatic test_trigger_idle();
    int t0;
    log_clear();
    trigger = 1'b1;
    t0 = cyc;
    trig_edges.push_back(cyc);
    tick();
    trigger = 1'b0;
    repeat (6) tick();
    n_vec++;
    if (log_w.size() != 1) begin
      n_err++;
      $display("FAIL trig_idle_count: got %0d words want 1", log_w.size());
    end else if (log_w[0] !== 17'h100F7 || log_c[0] - t0 != 2) begin
      n_err++;
      $display("FAIL trig_idle_word: got %h after %0d want 100f7 after 2", log_w[0], log_c[0] - t0);
    end
  endtask

  task automatic test_trigger_mid_frame();
    int k;
    log_clear();
    load(2, 10, 16'h0100, 1'b0);
    k = 0;
    while (!(m_in_frame && m_cnt == 3) && k < 50) begin
      tick();
      k++;
    end
    trigger = 1'b1;
    trig_edges.push_back(cyc);
    tick();
    trigger = 1'b0;
    run_drain(200, 1'b0);
    n_vec++;
    if (log_w.size() != 13) begin
      n_err++;
      $display("FAIL trig_mid_len: got %0d words want 13", log_w.size());
    end else if (log_w[11] !== 17'h100FD || log_w[12] !== 17'h100F7 || log_c[12] != log_c[11] + 1) begin
      n_err++;
      $display("FAIL trig_mid_order: got %h,%h gap %0d want 100fd,100f7 gap 1",
               log_w[11], log_w[12], log_c[12] - log_c[11]);
    end
  endtask

  task automatic test_split_frames();
    int sof_ch [$];
    int flen [$];
    int exp_ch [4] = '{0, 5, 0, 5};
    int exp_len [4] = '{256, 256, 44, 44};
    do_reset();
    log_clear();
    load(0, 300, 16'h0000, 1'b0);
    load(5, 300, 16'h5000, 1'b0);
    run_drain(2000, 1'b0);
    foreach (log_w[i]) begin
      if (log_w[i][16] && log_w[i][7:0] == 8'h1C) begin
        sof_ch.push_back(int'(log_w[i][11:8]));
        flen.push_back(0);
      end else if (!log_w[i][16] && flen.size() > 0) begin
        flen[flen.size()-1] = flen[flen.size()-1] + 1;
      end
    end
    n_vec++;
    if (sof_ch.size() != 4) begin
      n_err++;
      $display("FAIL split_frames: got %0d frames want 4", sof_ch.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (sof_ch[i] != exp_ch[i] || flen[i] != exp_len[i]) begin
          n_err++;
          $display("FAIL split_frame%0d: got ch%0d len %0d want ch%0d len %0d",
                   i, sof_ch[i], flen[i], exp_ch[i], exp_len[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    load(2, 10, 16'h0200, 1'b0);
    k = 0;
    while (!(m_in_frame && m_cnt == 3) && k < 50) begin
      tick();
      k++;
    end
    mon_en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (dout !== 16'h50BC || kchar !== 1'b1 || ack !== 16'h0) begin
        n_err++;
        $display("FAIL abort_idle: got %h k=%b ack=%h want 50bc k=1 ack=0", dout, kchar, ack);
      end
    end
    reset = 1'b0;
    mon_init();
    mon_en = 1'b1;
    log_clear();
    run_drain(200, 1'b0);
    n_vec++;
    if (log_w.size() != 8) begin
      n_err++;
      $display("FAIL abort_resume_len: got %0d words want 8", log_w.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (log_w[1+i] !== 17'(16'h0204 + 16'(i))) begin
          n_err++;
          $display("FAIL abort_resume%0d: got %h want %h", i, log_w[1+i], 16'h0204 + 16'(i));
        end
      end
      n_vec++;
      if (log_w[0] !== 17'h1021C || log_w[7] !== 17'h100FD) begin
        n_err++;
        $display("FAIL abort_resume_frame: got %h..%h want 1021c..100fd", log_w[0], log_w[7]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) begin
        if ($urandom_range(0, 2) == 0) load(c, $urandom_range(1, 40), 16'h0, 1'b1);
      end
      if (r == 2) load($urandom_range(0, 15), 260, 16'h0, 1'b1);
      run_drain(3000, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1;
    trigger = 1'b0;
    test_reset();
    test_single_frame();
    test_trigger_idle();
    test_trigger_mid_frame();
    test_split_frames();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; port list follows, clock and reset first.
REQ-002 clk  input  1  rising-edge system clock for all logic.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 data  input  256  16 channel FIFO read lanes; channel i on bits [16*i+15:16*i].
REQ-005 req  input  16  req[i]=1: channel i FIFO not empty; may drop in the cycle after a read.
REQ-006 ack  output  16  ack[i]: one-cycle read strobe to channel i FIFO, combinational.
REQ-007 trigger  input  1  one-cycle trigger pulse.
REQ-008 dout  output  16  registered link word.
REQ-009 kchar  output  1  registered; 1 = dout low byte is an 8b/10b K-character.

Function
REQ-010 FIFO protocol SHALL be: ack[i] high in cycle k reads one word, valid on lane i in cycle k+1; back-to-back strobes allowed.
REQ-011 ack[i] SHALL only be high when req[i]=1 in the same cycle; at most one ack bit high per cycle.
REQ-012 Link words SHALL be: IDLE 16'h50BC k=1; SOF {4'h0,ch[3:0],8'h1C} k=1; data words k=0; EOF 16'h00FD k=1; TRIG 16'h00F7 k=1.
REQ-013 States SHALL be IDLE, DATA, EOF.
REQ-014 IDLE: if trigger pending, next dout=TRIG, pending cleared, stay IDLE; trigger takes priority over granting.
REQ-015 IDLE, no pending trigger, any req high: select channel round-robin, first index at or after rr pointer with req high (wrapping 15->0); assert ack[ch] same cycle; next dout=SOF; count<=1; rr pointer<=ch+1 mod 16; go DATA.
REQ-016 IDLE, nothing pending: next dout=IDLE word.
REQ-017 DATA: ack[ch]=1 when req[ch]=1 and count<256; count increments per ack; stay DATA; else no ack, go EOF.
REQ-018 Any cycle following an ack: next dout<=lane[ch], kchar<=0, overriding state-driven words.
REQ-019 EOF: next dout=EOF word; go IDLE; a new grant may follow immediately (no idle gap required).
REQ-020 Frame SHALL carry 1..256 data words in FIFO order; a channel with >256 words is split across grants.
REQ-021 trigger SHALL set a pending flag on the clock edge it is sampled; a second trigger while pending SHALL be merged; trigger in the same cycle TRIG is issued re-arms pending.
REQ-022 Trigger during a frame SHALL be deferred until IDLE is reached after EOF.
REQ-023 Output stream SHALL be gapless: every cycle dout carries exactly one defined word.

Reset
REQ-024 Reset SHALL force dout=16'h50BC, kchar=1, ack=0, state IDLE, count=0, rr pointer=0, trigger pending=0 at the next edge.
REQ-025 Reset asserted mid-frame SHALL abort the frame without EOF; words already strobed are lost; ack=0 while reset high.
REQ-026 Reset deasserted: first grant evaluated in the first cycle after reset low.

Verification
REQ-027 Reset, all req=0 -> dout=16'h50BC, kchar=1 continuously, ack=0.
REQ-028 Channel 2 FIFO holding 0..9 (lane data[47:32]) -> SOF 16'h021C k=1, then 16'h0000..16'h0009 k=0 consecutive, EOF 16'h00FD k=1, then IDLE; exactly 10 ack[2] pulses.
REQ-029 Idle link, one-cycle trigger -> exactly one 16'h00F7 k=1 word within 2 cycles, then IDLE.
REQ-030 Trigger pulsed mid-frame of channel 2 -> TRIG emitted immediately after EOF, before any further SOF.
REQ-031 Channels 0 and 5 each holding 300 words -> frames ch0(256), ch5(256), ch0(44), ch5(44), each SOF with correct channel nibble.
REQ-032 Reset asserted after 3 data words of a frame -> next cycles dout=16'h50BC k=1, ack=0; remaining words sent in a new frame after reset.
